core_load_unit: RTL and testbench
=================================

CORE_LOAD_UNIT -- requirements
Module: core_load_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles spent in REQ without MEM_ACK before the load is aborted (range 1..255).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-003 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 START  input  1  SHALL be the load request strobe, sampled only in IDLE.
REQ-005 FUNCT3  input  3  SHALL be the load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-006 ADDR  input  32  SHALL be the effective byte address, captured with START.
REQ-007 RD  input  5  SHALL be the destination register index, captured with START.
REQ-008 MEM_REQ  output  1  SHALL be the memory read request, held high until acknowledged.
REQ-009 MEM_ADDR  output  32  SHALL be the word-aligned address: captured ADDR[31:2] followed by 2'b00.
REQ-010 MEM_ACK  input  1  SHALL indicate that MEM_RDATA is valid in this cycle.
REQ-011 MEM_RDATA  input  32  SHALL be the little-endian read word.
REQ-012 AWVALID  output  1  SHALL be the register-file write strobe.
REQ-013 AWADDR  output  5  SHALL be the register-file write index.
REQ-014 WDATA  output  32  SHALL be the register-file write data.
REQ-015 BUSY  output  1  SHALL be high in every state except IDLE.
REQ-016 DONE  output  1  SHALL be a one-cycle pulse on successful completion.
REQ-017 ERR  output  1  SHALL be a one-cycle pulse on an aborted load.

Function
REQ-018 The FSM SHALL use the states IDLE, REQ, WB and FAULT, with all outputs registered.
REQ-019 IDLE + START SHALL capture FUNCT3, ADDR and RD; the next state is REQ when the load is legal, else FAULT.
REQ-020 A load SHALL be illegal if FUNCT3 is not one of 000/001/010/100/101, if LH/LHU has ADDR[0]=1, or if LW has ADDR[1:0]!=00.
REQ-021 No memory request SHALL be issued for an illegal load.
REQ-022 In REQ, MEM_REQ SHALL be 1 and MEM_ADDR stable; MEM_ACK=1 SHALL latch the extracted result and go to WB.
REQ-023 The REQ cycle counter SHALL start at 0 on entry.
REQ-024 If the counter reaches TIMEOUT_CYCLES-1 without MEM_ACK, the FSM SHALL go to FAULT; MEM_ACK in that same cycle SHALL win (go to WB).
REQ-025 Byte extraction SHALL use byte lane ADDR[1:0] for LB/LBU and half-word lane ADDR[1] for LH/LHU.
REQ-026 LB/LH SHALL sign-extend to 32 bits, LBU/LHU SHALL zero-extend, and LW SHALL pass the word unchanged.
REQ-027 WB SHALL last exactly one cycle: DONE=1, AWADDR=RD and WDATA=result; AWVALID SHALL be 1 only when RD!=0; the next state is IDLE.
REQ-028 FAULT SHALL last exactly one cycle: ERR=1, AWVALID=0; the next state is IDLE.
REQ-029 START outside IDLE SHALL be ignored with no queuing.
REQ-030 Latency SHALL be: START at edge N, MEM_REQ high from N+1; MEM_ACK sampled at edge M gives AWVALID/DONE in cycle M+1; minimum START-to-write is 2 cycles.
REQ-031 A new START SHALL be accepted in the cycle after WB or FAULT (back-to-back loads).
REQ-032 MEM_ACK outside REQ SHALL be ignored.

Reset
REQ-033 RST=1 SHALL immediately force state IDLE; MEM_REQ, AWVALID, DONE, ERR and BUSY to 0; AWADDR, WDATA, MEM_ADDR and the counter to 0.
REQ-034 RST asserted mid-load SHALL abandon the load with no register write and no DONE/ERR pulse.
REQ-035 After RST deasserts, the block SHALL accept START on the first rising edge.

Verification
REQ-036 LB: ADDR=0x1003, RD=5, MEM_RDATA=0x80AABBCC, ACK after 3 cycles -> MEM_ADDR=0x1000, one AWVALID with AWADDR=5, WDATA=0xFFFFFF80, DONE pulse.
REQ-037 LHU: ADDR=0x2002, MEM_RDATA=0x9ABC1234 -> WDATA=0x00009ABC; LH with the same inputs -> WDATA=0xFFFF9ABC; LW at 0x2000 -> WDATA=0x9ABC1234.
REQ-038 Misaligned LW at ADDR=0x0006 and FUNCT3=011 -> MEM_REQ never asserted, ERR pulse 1 cycle after START, AWVALID=0.
REQ-039 TIMEOUT_CYCLES=4 with MEM_ACK held 0 -> MEM_REQ high 4 cycles then ERR; ACK arriving in the 4th cycle -> DONE, no ERR.
REQ-040 RD=0 with LW -> DONE pulse, AWVALID stays 0; a START while BUSY is ignored; a back-to-back START the cycle after DONE is accepted.
REQ-041 RST pulsed while in REQ -> all outputs 0 asynchronously, no DONE/ERR/AWVALID, and the next load completes normally.

Source files
------------

// File: rtl/core_load_unit.sv
// ---------------------------------------------------------------------------
// core_load_unit
//
// Executes one RISC-V style load (LB/LH/LW/LBU/LHU) per START strobe: checks
// alignment and type, issues a word-aligned memory read, extracts and extends
// the addressed byte/half-word, and writes the result to the register file.
// Illegal loads and loads whose memory read times out end in a one-cycle ERR.
//
// Ports
//   CLK        single clock, rising edge
//   RST        asynchronous, active-high reset
//   START      load request strobe (sampled only when idle)
//   FUNCT3     load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   ADDR       effective byte address, captured with START
//   RD         destination register index, captured with START
//   MEM_REQ    memory read request, held until MEM_ACK
//   MEM_ADDR   word-aligned read address
//   MEM_ACK    MEM_RDATA valid this cycle
//   MEM_RDATA  little-endian read word
//   AWVALID    register-file write strobe (suppressed for RD == 0)
//   AWADDR     register-file write index
//   WDATA      register-file write data
//   BUSY       high whenever a load is in flight
//   DONE       one-cycle pulse on successful completion
//   ERR        one-cycle pulse on an aborted load
// ---------------------------------------------------------------------------
module core_load_unit #(
    parameter int TIMEOUT_CYCLES = 255   // REQ cycles without MEM_ACK before abort, 1..255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [4:0]  RD,
    output logic        MEM_REQ,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        AWVALID,
    output logic [4:0]  AWADDR,
    output logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Last counter value tolerated in REQ before the load is aborted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WB,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q;
    logic [1:0]  lo_q;         // byte offset within the word
    logic [4:0]  rd_q;
    logic        capture;

    // Next values of the registered outputs.
    logic        mem_req_d;
    logic [31:0] mem_addr_d;
    logic        awvalid_d;
    logic [4:0]  awaddr_d;
    logic [31:0] wdata_d;
    logic        busy_d;
    logic        done_d;
    logic        err_d;

    // Type and alignment legality of a load.
    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = ~lo[0];
            F3_LW:         ok = (lo == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Select the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LBU:  r = {24'd0, b};
            F3_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign capture = (state_q == ST_IDLE) && START;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so all flops
    // update from the same pre-edge values, whatever the statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            funct3_q <= 3'd0;
            lo_q     <= 2'd0;
            rd_q     <= 5'd0;
            MEM_REQ  <= 1'b0;
            MEM_ADDR <= 32'd0;
            AWVALID  <= 1'b0;
            AWADDR   <= 5'd0;
            WDATA    <= 32'd0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (capture) begin
                funct3_q <= FUNCT3;
                lo_q     <= ADDR[1:0];
                rd_q     <= RD;
            end
            MEM_REQ  <= mem_req_d;
            MEM_ADDR <= mem_addr_d;
            AWVALID  <= awvalid_d;
            AWADDR   <= awaddr_d;
            WDATA    <= wdata_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
            ERR      <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: defaults at the top of each combinational block guarantee every
    // signal is assigned on every path, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    cnt_d   = 8'd0;
                    state_d = load_legal(FUNCT3, ADDR[1:0]) ? ST_REQ : ST_FAULT;
                end
            end
            ST_REQ: begin
                // An acknowledge in the final allowed cycle still completes.
                if (MEM_ACK) begin
                    state_d = ST_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WB:    state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: decoded from the next state so the outputs leave flops
    // in the same cycle the state does.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req_d  = (state_d == ST_REQ);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_WB);
        err_d      = (state_d == ST_FAULT);
        awvalid_d  = (state_d == ST_WB) && (rd_q != 5'd0);
        mem_addr_d = MEM_ADDR;
        awaddr_d   = AWADDR;
        wdata_d    = WDATA;
        if (capture) begin
            mem_addr_d = {ADDR[31:2], 2'b00};
        end
        // Result is latched on the acknowledge and presented during WB.
        if ((state_q == ST_REQ) && (state_d == ST_WB)) begin
            awaddr_d = rd_q;
            wdata_d  = extract(funct3_q, lo_q, MEM_RDATA);
        end
    end

endmodule

// File: tb/tb_core_load_unit.sv
// ---------------------------------------------------------------------------
// tb_core_load_unit
//
// Directed loads against core_load_unit with TIMEOUT_CYCLES = 4. The expected
// output timeline of each load is derived from the load's rules (legality,
// acknowledge position, timeout length, lane extraction by arithmetic), and
// a single negedge process compares the DUT against it every cycle. Hand
// literals pin the extracted results of the documented vectors.
// ---------------------------------------------------------------------------
module tb_core_load_unit;

    localparam int TIMEOUT = 4;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR;
    logic [4:0]  RD;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        AWVALID;
    logic [4:0]  AWADDR;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    core_load_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .FUNCT3    (FUNCT3),
        .ADDR      (ADDR),
        .RD        (RD),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .AWVALID   (AWVALID),
        .AWADDR    (AWADDR),
        .WDATA     (WDATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs after the coming rising edge.
    logic        chk_en = 1'b0;
    logic        exp_mem_req, exp_busy, exp_done, exp_err, exp_awvalid;
    logic [31:0] exp_mem_addr, exp_wdata;
    logic [4:0]  exp_awaddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: outputs are stable at the falling edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("BUSY",    {31'd0, BUSY},    {31'd0, exp_busy});
            check("MEM_REQ", {31'd0, MEM_REQ}, {31'd0, exp_mem_req});
            check("DONE",    {31'd0, DONE},    {31'd0, exp_done});
            check("ERR",     {31'd0, ERR},     {31'd0, exp_err});
            check("AWVALID", {31'd0, AWVALID}, {31'd0, exp_awvalid});
            if (exp_mem_req) check("MEM_ADDR", MEM_ADDR, exp_mem_addr);
            if (exp_done) begin
                check("AWADDR", {27'd0, AWADDR}, {27'd0, exp_awaddr});
                check("WDATA",  WDATA, exp_wdata);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) return (addr % 2) == 0;
        if (f3 == 3'b010)                 return (addr % 4) == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_result(input logic [2:0] f3, input logic [31:0] addr,
                                                 input logic [31:0] word);
        logic [31:0] v;
        int          sh;
        case (f3)
            3'b000, 3'b100: begin
                sh = 8 * int'(addr[1:0]);
                v  = (word >> sh) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                sh = 16 * int'(addr[1]);
                v  = (word >> sh) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic exp_idle();
        exp_mem_req = 1'b0;
        exp_busy    = 1'b0;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_awvalid = 1'b0;
    endtask

    // One load starting at the current drive slot. ack_at = REQ cycle (1-based)
    // in which MEM_ACK is driven; 0 = never. poke drives stray START/MEM_ACK
    // while the unit is busy. Ends in the first idle drive slot afterwards.
    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] rdata, input int ack_at,
                        input bit use_lit, input logic [31:0] lit, input bit poke);
        bit          legal;
        logic [31:0] res;
        legal = model_legal(f3, addr);
        res   = model_result(f3, addr, rdata);

        START = 1'b1; FUNCT3 = f3; ADDR = addr; RD = rd;
        MEM_ACK = poke; MEM_RDATA = rdata;
        exp_idle();
        exp_busy = 1'b1;
        if (legal) begin
            exp_mem_req  = 1'b1;
            exp_mem_addr = addr & 32'hFFFF_FFFC;
        end else begin
            exp_err = 1'b1;
        end
        step();
        START = 1'b0; MEM_ACK = 1'b0;
        // Inputs scrambled after capture: the unit must not re-sample them.
        FUNCT3 = 3'($urandom()); ADDR = $urandom(); RD = 5'($urandom());

        if (legal) begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                MEM_ACK = (i == ack_at);
                START   = poke && (i == 1);
                exp_idle();
                exp_busy = 1'b1;
                if (i == ack_at) begin
                    exp_done    = 1'b1;
                    exp_awvalid = (rd != 5'd0);
                    exp_awaddr  = rd;
                    exp_wdata   = res;
                end else if (i == TIMEOUT) begin
                    exp_err = 1'b1;
                end else begin
                    exp_mem_req = 1'b1;
                end
                step();
                START = 1'b0; MEM_ACK = 1'b0;
                if (i == ack_at) begin
                    if (use_lit) check("WDATA_literal", WDATA, lit);
                    break;
                end
            end
        end

        // DONE/ERR cycle: stray START and MEM_ACK here must be ignored.
        START = poke; MEM_ACK = poke;
        exp_idle();
        step();
        START = 1'b0; MEM_ACK = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_MEM_REQ"},  {31'd0, MEM_REQ}, 32'd0);
        check({tag, "_AWVALID"},  {31'd0, AWVALID}, 32'd0);
        check({tag, "_DONE"},     {31'd0, DONE},    32'd0);
        check({tag, "_ERR"},      {31'd0, ERR},     32'd0);
        check({tag, "_BUSY"},     {31'd0, BUSY},    32'd0);
        check({tag, "_AWADDR"},   {27'd0, AWADDR},  32'd0);
        check({tag, "_WDATA"},    WDATA,            32'd0);
        check({tag, "_MEM_ADDR"}, MEM_ADDR,         32'd0);
    endtask

    // Reset asserted asynchronously while the unit waits in REQ.
    task automatic reset_mid_load();
        START = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h0000_5000; RD = 5'd9;
        MEM_ACK = 1'b0; MEM_RDATA = 32'h1111_2222;
        exp_idle();
        exp_busy = 1'b1; exp_mem_req = 1'b1; exp_mem_addr = 32'h0000_5000;
        step();
        START = 1'b0;
        step();
        check("MEM_REQ_before_reset", {31'd0, MEM_REQ}, 32'd1);
        RST = 1'b1;
        #1;
        reset_checks("midload_reset");
        exp_idle();
        step();
        MEM_ACK = 1'b1;   // acknowledge of the abandoned read arrives late
        step();
        MEM_ACK = 1'b0;
        RST = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        RST = 1'b1; START = 1'b0; FUNCT3 = 3'd0; ADDR = 32'd0; RD = 5'd0;
        MEM_ACK = 1'b0; MEM_RDATA = 32'd0;
        exp_idle();
        exp_mem_addr = 32'd0; exp_wdata = 32'd0; exp_awaddr = 5'd0;
        #3;
        reset_checks("por");
        step();
        RST = 1'b0;
        chk_en = 1'b1;

        // START on the first edge after reset release.
        // LB lane 3 of 0x80AABBCC: 0x80 sign-extended; MEM_ADDR 0x1000.
        load(3'b000, 32'h0000_1003, 5'd5,  32'h80AA_BBCC, 3, 1'b1, 32'hFFFF_FF80, 1'b0);
        load(3'b101, 32'h0000_2002, 5'd7,  32'h9ABC_1234, 1, 1'b1, 32'h0000_9ABC, 1'b0);
        load(3'b001, 32'h0000_2002, 5'd7,  32'h9ABC_1234, 2, 1'b1, 32'hFFFF_9ABC, 1'b0);
        // Acknowledge in the last allowed REQ cycle wins over the timeout.
        load(3'b010, 32'h0000_2000, 5'd8,  32'h9ABC_1234, TIMEOUT, 1'b1, 32'h9ABC_1234, 1'b0);
        // Illegal loads: no request, ERR one cycle after START.
        load(3'b010, 32'h0000_0006, 5'd4,  32'h0, 0, 1'b0, 32'h0, 1'b0);
        load(3'b011, 32'h0000_0000, 5'd4,  32'h0, 0, 1'b0, 32'h0, 1'b0);
        load(3'b101, 32'h0000_0001, 5'd4,  32'h0, 0, 1'b0, 32'h0, 1'b1);
        load(3'b111, 32'h0000_0004, 5'd4,  32'h0, 0, 1'b0, 32'h0, 1'b0);
        // Timeout: MEM_REQ for TIMEOUT cycles then ERR.
        load(3'b010, 32'h0000_3000, 5'd6,  32'h0, 0, 1'b0, 32'h0, 1'b0);
        // RD = 0: DONE without a write; stray START/ACK while busy.
        load(3'b010, 32'h0000_0040, 5'd0,  32'hDEAD_BEEF, 2, 1'b1, 32'hDEAD_BEEF, 1'b1);
        // Back-to-back loads.
        load(3'b100, 32'h0000_1001, 5'd31, 32'h1234_F6AA, 1, 1'b1, 32'h0000_00F6, 1'b0);
        load(3'b001, 32'h0000_0000, 5'd2,  32'h0000_8001, 1, 1'b1, 32'hFFFF_8001, 1'b1);

        reset_mid_load();
        load(3'b000, 32'h0000_0000, 5'd3,  32'h0000_007F, 1, 1'b1, 32'h0000_007F, 1'b0);
        load(3'b000, 32'h0000_0002, 5'd1,  32'h00C5_0000, 2, 1'b1, 32'hFFFF_FFC5, 1'b0);

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
